countdown_controller: RTL

//  Producer side of the display interface: owns the mm:ss countdown value and drives the

---
 rtl/counter_pkg.sv | 63 ++++++
 rtl/button_debounce.sv | 62 ++++++
 rtl/countdown_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for the mm:ss countdown controller.
//  - state_t : controller FSM states
//  - bcd_t   : one two-digit BCD field {tens, units}
//  - FLICK_* : blink codes presented to the seven-segment driver
//  - bcd_inc / bcd_dec : modulo-60 BCD step helpers
package counter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_MIN = 3'd1,
        ST_SET_SEC = 3'd2,
        ST_RUN     = 3'd3,
        ST_PAUSE   = 3'd4,
        ST_EXPIRED = 3'd5
    } state_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    localparam logic [1:0] FLICK_NONE = 2'b00;
    localparam logic [1:0] FLICK_SEC  = 2'b01;
    localparam logic [1:0] FLICK_MIN  = 2'b10;

    localparam logic [3:0] TENS_MAX  = 4'd5;
    localparam logic [3:0] UNITS_MAX = 4'd9;

    // 59 wraps to 00.
    function automatic bcd_t bcd_inc(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.units == UNITS_MAX) begin
            r.units = 4'd0;
            r.tens  = (v.tens == TENS_MAX) ? 4'd0 : v.tens + 4'd1;
        end else begin
            r.units = v.units + 4'd1;
        end
        return r;
    endfunction

    // 00 wraps to 59; the caller borrows from the next field when the input is 00.
    function automatic bcd_t bcd_dec(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.units != 4'd0) begin
            r.units = v.units - 4'd1;
        end else begin
            r.units = UNITS_MAX;
            r.tens  = (v.tens == 4'd0) ? TENS_MAX : v.tens - 4'd1;
        end
        return r;
    endfunction

    function automatic logic [1:0] flick_code(input state_t s);
        case (s)
            ST_SET_MIN: flick_code = FLICK_MIN;
            ST_SET_SEC: flick_code = FLICK_SEC;
            default:    flick_code = FLICK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioner: two-flop synchroniser, stability counter and
// rising-edge pulse generator.
//  clk, rst_n : clock, asynchronous active-low reset
//  btn        : raw (asynchronous, bouncy) button level
//  pulse      : one-cycle pulse when a new pressed level has been accepted
// After reset the first stable level is adopted silently as the baseline, so a
// button held through reset never produces a pulse until released and pressed.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             primed_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronise, then require DEBOUNCE_CYCLES identical samples before accepting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            primed_q <= 1'b0;
            cnt_q    <= '0;
            pulse    <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            pulse   <= 1'b0;
            if (!primed_q) begin
                // Baseline acquisition: track the level, no pulses.
                level_q <= sync2_q;
                if (sync2_q != level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    primed_q <= 1'b1;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                pulse   <= sync2_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_controller.sv
// mm:ss countdown controller feeding the seven-segment display block.
//  clk, rst_n   : clock, asynchronous active-low reset
//  btn_mode_i   : raw button, IDLE -> SET_MIN -> SET_SEC -> IDLE (PAUSE -> IDLE)
//  btn_inc_i    : raw button, increments the field being set
//  btn_start_i  : raw button, start / pause / resume
//  min_o, sec_o : BCD minutes / seconds {tens, units}
//  flick_o      : blink select (10 minutes, 01 seconds, 00 none)
//  time_out_o   : high while the countdown has expired
module countdown_controller
    import counter_pkg::*;
#(
    parameter int unsigned TICK_CYCLES     = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic       btn_start_i,
    output logic [7:0] min_o,
    output logic [7:0] sec_o,
    output logic [1:0] flick_o,
    output logic       time_out_o
);

    localparam int unsigned TICK_W = $clog2(TICK_CYCLES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    logic mode_pulse;
    logic inc_pulse;
    logic start_pulse;

    state_t            state_q, state_d;
    bcd_t              min_q, min_d;
    bcd_t              sec_q, sec_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]        flick_q, flick_d;
    logic              time_out_q, time_out_d;

    logic mode_ev_c;
    logic start_ev_c;
    logic inc_ev_c;
    logic tick_c;
    logic is_zero_c;
    bcd_t sec_dec_c;
    bcd_t min_dec_c;
    logic dec_zero_c;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_mode_i),
        .pulse (mode_pulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_inc_i),
        .pulse (inc_pulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_start_i),
        .pulse (start_pulse)
    );

    // Coincident pulses: mode beats start beats inc, losers are dropped.
    assign mode_ev_c  = mode_pulse;
    assign start_ev_c = start_pulse & ~mode_pulse;
    assign inc_ev_c   = inc_pulse & ~mode_pulse & ~start_pulse;

    assign tick_c    = (state_q == ST_RUN) && (tick_cnt_q == TICK_LAST);
    assign is_zero_c = (min_q == '0) && (sec_q == '0);

    // One-second decrement with borrow from minutes when seconds are 00.
    assign sec_dec_c  = bcd_dec(sec_q);
    assign min_dec_c  = (sec_q == '0) ? bcd_dec(min_q) : min_q;
    assign dec_zero_c = (sec_dec_c == '0) && (min_dec_c == '0);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            min_q      <= '0;
            sec_q      <= '0;
            tick_cnt_q <= '0;
            flick_q    <= FLICK_NONE;
            time_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            tick_cnt_q <= tick_cnt_d;
            flick_q    <= flick_d;
            time_out_q <= time_out_d;
        end
    end

    // Next-state, value and output logic.
    always_comb begin
        state_d    = state_q;
        min_d      = min_q;
        sec_d      = sec_q;
        tick_cnt_d = tick_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (mode_ev_c) begin
                    state_d = ST_SET_MIN;
                end else if (start_ev_c && !is_zero_c) begin
                    state_d    = ST_RUN;
                    tick_cnt_d = '0;
                end
            end
            ST_SET_MIN: begin
                if (mode_ev_c) begin
                    state_d = ST_SET_SEC;
                end else if (inc_ev_c) begin
                    min_d = bcd_inc(min_q);
                end
            end
            ST_SET_SEC: begin
                if (mode_ev_c) begin
                    state_d = ST_IDLE;
                end else if (inc_ev_c) begin
                    sec_d = bcd_inc(sec_q);
                end
            end
            ST_RUN: begin
                tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
                if (tick_c) begin
                    sec_d = sec_dec_c;
                    min_d = min_dec_c;
                end
                if (start_ev_c) begin
                    state_d = ST_PAUSE;
                end
                // Reaching 00:00 overrides a coincident pause.
                if (tick_c && dec_zero_c) begin
                    state_d = ST_EXPIRED;
                end
            end
            ST_PAUSE: begin
                if (mode_ev_c) begin
                    state_d = ST_IDLE;
                end else if (start_ev_c) begin
                    state_d    = ST_RUN;
                    tick_cnt_d = '0;
                end
            end
            ST_EXPIRED: begin
                if (mode_ev_c || start_ev_c || inc_ev_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        flick_d = flick_code(state_d);
        // Rises one cycle after the value lands on 00:00, drops with the exit pulse.
        time_out_d = (state_q == ST_EXPIRED) && (state_d == ST_EXPIRED);
    end

    assign min_o      = min_q;
    assign sec_o      = sec_q;
    assign flick_o    = flick_q;
    assign time_out_o = time_out_q;

endmodule
